// File: rtl/piece_engine_arbiter.sv
// piece_engine_arbiter: shares one piece engine among NUM_CLIENTS requesters; optional watchdog via ARB_WATCHDOG_EN
module piece_engine_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CLIENTS-1:0]   req,
    input  logic [6*NUM_CLIENTS-1:0] req_pos,
    output logic [NUM_CLIENTS-1:0]   grant,
    output logic [NUM_CLIENTS-1:0]   done,
    output logic [5:0]               eng_position,
    output logic                     eng_update,
    input  logic                     eng_ready,
    input  logic [1:0]               eng_check,
    output logic [1:0]               result_check,
    output logic                     busy,
    output logic                     err_timeout
);
    localparam int IW = $clog2(NUM_CLIENTS);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_RDY, DONE} state_t;

    state_t                 state;
    logic [IW-1:0]          p;
    logic [IW-1:0]          win;
    logic [NUM_CLIENTS-1:0] win_oh;
    logic [5:0]             win_pos;
    logic                   found;
    logic                   timeout;

    assign busy = state != IDLE;

    // winner search: first pass from pointer upward (round-robin only), second pass from 0 wraps around
    always_comb begin
        win     = '0;
        win_oh  = '0;
        win_pos = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && req[i] && (ARB_MODE == 0 || IW'(i) >= p)) begin
                found     = 1'b1;
                win       = IW'(i);
                win_oh[i] = 1'b1;
                win_pos   = req_pos[6*i +: 6];
            end
        end
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                win       = IW'(i);
                win_oh[i] = 1'b1;
                win_pos   = req_pos[6*i +: 6];
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    logic [15:0] wd_cnt;

    assign timeout = (state == WAIT_ACK || state == WAIT_RDY) && wd_cnt == 16'(TIMEOUT_CYCLES - 1);

    // watchdog counts waiting cycles; err_timeout pulses in the DONE cycle a timeout leads to
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout;
            wd_cnt      <= state == ISSUE ? '0 : (state == WAIT_ACK || state == WAIT_RDY) ? wd_cnt + 16'd1 : wd_cnt;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // transaction FSM with registered grant, position, strobe, done and result
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            done         <= '0;
            eng_update   <= 1'b0;
            eng_position <= '0;
            result_check <= '0;
            p            <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state        <= ISSUE;
                    grant        <= win_oh;
                    eng_position <= win_pos;
                    eng_update   <= 1'b1;
                    p            <= win == IW'(NUM_CLIENTS - 1) ? '0 : win + 1'b1;
                end
                ISSUE: begin
                    state      <= WAIT_ACK;
                    eng_update <= 1'b0;
                end
                WAIT_ACK: if (timeout) begin
                    state        <= DONE;
                    done         <= grant;
                    result_check <= 2'b00;
                end else if (!eng_ready) begin
                    state <= WAIT_RDY;
                end
                WAIT_RDY: if (timeout) begin
                    state        <= DONE;
                    done         <= grant;
                    result_check <= 2'b00;
                end else if (eng_ready) begin
                    state        <= DONE;
                    done         <= grant;
                    result_check <= eng_check;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    grant <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piece_engine_arbiter.sv
// tb_piece_engine_arbiter: directed checks of a fixed-priority and a round-robin arbiter instance
module tb_piece_engine_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  f_req, r_req;
    logic [23:0] f_pos, r_pos;
    logic        f_ready, r_ready;
    logic [1:0]  f_check, r_check;
    logic [3:0]  f_grant, f_done, r_grant, r_done;
    logic [5:0]  f_epos, r_epos;
    logic        f_upd, r_upd, f_busy, r_busy, f_err, r_err;
    logic [1:0]  f_rc, r_rc;
    int          tests = 0;
    int          fails = 0;
    int          bad;

    always #5 clk = ~clk;

    piece_engine_arbiter #(.NUM_CLIENTS(4), .ARB_MODE(0), .TIMEOUT_CYCLES(10)) u_fixed (
        .clk(clk), .reset(reset), .req(f_req), .req_pos(f_pos), .grant(f_grant), .done(f_done),
        .eng_position(f_epos), .eng_update(f_upd), .eng_ready(f_ready), .eng_check(f_check),
        .result_check(f_rc), .busy(f_busy), .err_timeout(f_err)
    );

    piece_engine_arbiter #(.NUM_CLIENTS(4), .ARB_MODE(1), .TIMEOUT_CYCLES(10)) u_rr (
        .clk(clk), .reset(reset), .req(r_req), .req_pos(r_pos), .grant(r_grant), .done(r_done),
        .eng_position(r_epos), .eng_update(r_upd), .eng_ready(r_ready), .eng_check(r_check),
        .result_check(r_rc), .busy(r_busy), .err_timeout(r_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        f_req = '0; r_req = '0;
        f_pos = '0; r_pos = '0;
        f_ready = 1'b1; r_ready = 1'b1;
        f_check = '0; r_check = '0;
        tick; tick;
        chk("rst_grant", {28'd0, f_grant}, 32'h0);
        chk("rst_busy", {31'd0, f_busy}, 32'h0);
        chk("rst_done_upd_err", {28'd0, f_done, f_upd, f_err}, 32'h0);
        chk("rst_pos_rc", {24'd0, f_epos, f_rc}, 32'h0);
        chk("rst_rr_outputs", {r_grant, r_done, r_epos, r_rc, r_upd, r_busy, r_err}, 32'h0);
        reset = 1'b0;

        f_pos = {6'd0, 6'd45, 6'd12, 6'd0};
        f_req = 4'b0110;
        tick;
        chk("fx_issue_grant", {28'd0, f_grant}, 32'h2);
        chk("fx_issue_upd", {31'd0, f_upd}, 32'h1);
        chk("fx_issue_pos", {26'd0, f_epos}, 32'd12);
        chk("fx_issue_busy", {31'd0, f_busy}, 32'h1);
        f_ready = 1'b0;
        tick;
        chk("fx_ack_upd", {31'd0, f_upd}, 32'h0);
        tick; tick;
        chk("fx_rdy_grant_done", {24'd0, f_grant, f_done}, 32'h20);
        f_ready = 1'b1; f_check = 2'b01;
        tick;
        chk("fx_done1", {28'd0, f_done}, 32'h2);
        chk("fx_done1_rc", {30'd0, f_rc}, 32'h1);
        f_req = 4'b0100;
        tick;
        chk("fx_idle_gap", {27'd0, f_grant, f_busy}, 32'h0);
        tick;
        chk("fx_grant2", {28'd0, f_grant}, 32'h4);
        chk("fx_pos2", {26'd0, f_epos}, 32'd45);
        f_ready = 1'b0;
        tick; tick;
        f_ready = 1'b1; f_check = 2'b10;
        tick;
        chk("fx_done2", {26'd0, f_done, f_rc}, {26'd0, 4'b0100, 2'b10});
        f_req = 4'b0000;
        tick;
        chk("fx_done2_clear", {27'd0, f_done, f_busy}, 32'h0);

        f_pos = {6'd0, 6'd37, 6'd12, 6'd0};
        f_req = 4'b0100;
        tick;
        f_req = 4'b0000;
        chk("p36_issue", {21'd0, f_grant, f_epos, f_upd}, {21'd0, 4'b0100, 6'd37, 1'b1});
        f_ready = 1'b0;
        tick;
        chk("p36_ack", {21'd0, f_grant, f_epos, f_upd}, {21'd0, 4'b0100, 6'd37, 1'b0});
        tick;
        chk("p36_rdy", {21'd0, f_grant, f_epos, f_upd}, {21'd0, 4'b0100, 6'd37, 1'b0});
        f_ready = 1'b1;
        tick;
        chk("p36_done", {21'd0, f_done, f_epos, f_upd}, {21'd0, 4'b0100, 6'd37, 1'b0});
        tick;
        chk("p36_idle", {27'd0, f_done, f_busy}, 32'h0);

        r_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk($sformatf("rr_grant%0d", k), {28'd0, r_grant}, 32'(1 << (k % 4)));
            r_ready = 1'b0;
            tick; tick;
            r_ready = 1'b1;
            tick;
            chk($sformatf("rr_done%0d", k), {28'd0, r_done}, 32'(1 << (k % 4)));
            tick;
        end

        r_req = 4'b0000;
        tick;
        r_req = 4'b0010;
        tick;
        chk("p37_grant1", {28'd0, r_grant}, 32'h2);
        r_req = 4'b0000;
        r_ready = 1'b0;
        tick; tick;
        chk("p37_in_wait", {27'd0, r_grant, r_busy}, 32'h5);
        reset = 1'b1;
        tick;
        chk("p37_reset", {20'd0, r_grant, r_done, r_busy, r_upd, r_rc}, 32'h0);
        chk("p37_reset_pos", {26'd0, r_epos}, 32'h0);
        reset = 1'b0;
        r_ready = 1'b1;
        r_req = 4'b1111;
        tick;
        chk("p37_restart", {28'd0, r_grant}, 32'h1);
        r_req = 4'b0000;

        f_check = 2'b11;
        f_ready = 1'b1;
        f_req = 4'b0001;
        tick;
        chk("wd_issue", {28'd0, f_grant}, 32'h1);
        f_req = 4'b0000;
`ifdef ARB_WATCHDOG_EN
        repeat (10) tick;
        chk("wd_before", {27'd0, f_done, f_err}, 32'h0);
        tick;
        chk("wd_done", {28'd0, f_done}, 32'h1);
        chk("wd_err", {31'd0, f_err}, 32'h1);
        chk("wd_rc", {30'd0, f_rc}, 32'h0);
        tick;
        chk("wd_after", {30'd0, f_err, f_busy}, 32'h0);
`else
        bad = 0;
        repeat (1000) begin
            tick;
            if (f_err || f_done != 4'b0 || !f_busy || f_grant != 4'b0001) bad++;
        end
        chk("nowd_stuck_cycles", bad, 32'h0);
        chk("nowd_err", {31'd0, f_err}, 32'h0);
`endif
        reset = 1'b1;
        tick;
        chk("final_reset", {23'd0, f_grant, f_busy, r_grant}, 32'h0);
        reset = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
